// File: rtl/uart_tx.sv
// ---------------------------------------------------------------------------
// uart_tx -- UART serializer sitting on the read side of an async FIFO.
//
// Pops bytes through the FIFO show-ahead read port (rdata is valid whenever
// rempty=0) and sends each one as: start bit, DSIZE data bits LSB first,
// optional parity bit, then one or two stop bits. Baud divisor and frame
// format are captured together with the byte at pop time, so changes to the
// configuration inputs mid-frame only affect the next frame.
//
// Ports:
//   rclk, rrst_n   read-domain clock and asynchronous active-low reset
//   tx_en          permits starting a new frame (a running frame completes)
//   baud_div       bit period = baud_div+1 rclk cycles
//   parity_en      append a parity bit after the data bits
//   parity_odd     1 = odd parity, 0 = even parity
//   two_stop       1 = two stop bits, 0 = one stop bit
//   rempty, rdata  FIFO empty flag and head word
//   rinc           combinational one-cycle pop strobe to the FIFO
//   txd            serial line, idle high (registered)
//   busy           high from START through the last stop bit (registered)
//   frame_done     pulse in the final cycle of the last stop bit (registered)
// ---------------------------------------------------------------------------
module uart_tx #(
  parameter int DSIZE     = 8,
  parameter int DIV_WIDTH = 16
) (
  input  logic                 rclk,
  input  logic                 rrst_n,
  input  logic                 tx_en,
  input  logic [DIV_WIDTH-1:0] baud_div,
  input  logic                 parity_en,
  input  logic                 parity_odd,
  input  logic                 two_stop,
  input  logic                 rempty,
  input  logic [DSIZE-1:0]     rdata,
  output logic                 rinc,
  output logic                 txd,
  output logic                 busy,
  output logic                 frame_done
);

  localparam int CW = (DSIZE > 1) ? $clog2(DSIZE) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(DSIZE - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  // Parity of the captured byte; odd parity is the inverse of the XOR.
  function automatic logic calc_parity(input logic [DSIZE-1:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction

  state_t               state_r, state_s;
  logic [DIV_WIDTH-1:0] baud_cnt_r, baud_cnt_s;
  logic [DIV_WIDTH-1:0] div_r, div_s;
  logic [CW-1:0]        bit_cnt_r, bit_cnt_s;
  logic                 stop_cnt_r, stop_cnt_s;
  logic [DSIZE-1:0]     shift_r, shift_s;
  logic                 par_bit_r, par_bit_s;
  logic                 par_en_r, par_en_s;
  logic                 two_stop_r, two_stop_s;
  logic                 txd_r, txd_s;
  logic                 busy_r, busy_s;
  logic                 done_r, done_s;
  logic                 bit_end_s;
  logic                 can_pop_s;
  logic                 load_s;

  // Next-state, counter and pop logic; output values are derived from the
  // next state so that txd/busy/frame_done can be registered without lag.
  always_comb begin
    state_s    = state_r;
    baud_cnt_s = baud_cnt_r;
    div_s      = div_r;
    bit_cnt_s  = bit_cnt_r;
    stop_cnt_s = stop_cnt_r;
    shift_s    = shift_r;
    par_bit_s  = par_bit_r;
    par_en_s   = par_en_r;
    two_stop_s = two_stop_r;
    load_s     = 1'b0;
    rinc       = 1'b0;
    txd_s      = 1'b1;
    busy_s     = 1'b0;
    done_s     = 1'b0;

    bit_end_s = (baud_cnt_r == DIV_WIDTH'(0));
    // rrst_n gating keeps the pop strobe quiet while reset is held.
    can_pop_s = tx_en & ~rempty & rrst_n;

    case (state_r)
      IDLE: begin
        if (can_pop_s) begin
          load_s = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      START: begin
        if (bit_end_s) begin
          state_s    = DATA;
          baud_cnt_s = div_r;
          bit_cnt_s  = CW'(0);
        end else begin
          baud_cnt_s = baud_cnt_r - DIV_WIDTH'(1);
        end
      end
      DATA: begin
        if (bit_end_s) begin
          baud_cnt_s = div_r;
          shift_s    = shift_r >> 1;
          if (bit_cnt_r == LAST_BIT) begin
            state_s    = par_en_r ? PARITY : STOP;
            stop_cnt_s = 1'b0;
          end else begin
            bit_cnt_s = bit_cnt_r + CW'(1);
          end
        end else begin
          baud_cnt_s = baud_cnt_r - DIV_WIDTH'(1);
        end
      end
      PARITY: begin
        if (bit_end_s) begin
          state_s    = STOP;
          stop_cnt_s = 1'b0;
          baud_cnt_s = div_r;
        end else begin
          baud_cnt_s = baud_cnt_r - DIV_WIDTH'(1);
        end
      end
      STOP: begin
        if (bit_end_s) begin
          if (stop_cnt_r == two_stop_r) begin
            // Last stop cycle: chain straight into the next frame if possible.
            if (can_pop_s) begin
              load_s = 1'b1;
            end else begin
              state_s = IDLE;
            end
          end else begin
            stop_cnt_s = 1'b1;
            baud_cnt_s = div_r;
          end
        end else begin
          baud_cnt_s = baud_cnt_r - DIV_WIDTH'(1);
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase

    // Pop the FIFO head and latch the whole frame configuration with it.
    if (load_s) begin
      rinc       = 1'b1;
      state_s    = START;
      shift_s    = rdata;
      par_bit_s  = calc_parity(rdata, parity_odd);
      div_s      = baud_div;
      baud_cnt_s = baud_div;
      par_en_s   = parity_en;
      two_stop_s = two_stop;
    end else begin
      rinc = 1'b0;
    end

    case (state_s)
      IDLE:    txd_s = 1'b1;
      START:   txd_s = 1'b0;
      DATA:    txd_s = shift_s[0];
      PARITY:  txd_s = par_bit_s;
      STOP:    txd_s = 1'b1;
      default: txd_s = 1'b1;
    endcase

    busy_s = (state_s != IDLE);
    done_s = (state_s == STOP) && (baud_cnt_s == DIV_WIDTH'(0)) &&
             (stop_cnt_s == two_stop_s);
  end

  // State, datapath and registered output flops with async reset.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      state_r    <= IDLE;
      baud_cnt_r <= DIV_WIDTH'(0);
      div_r      <= DIV_WIDTH'(0);
      bit_cnt_r  <= CW'(0);
      stop_cnt_r <= 1'b0;
      shift_r    <= DSIZE'(0);
      par_bit_r  <= 1'b0;
      par_en_r   <= 1'b0;
      two_stop_r <= 1'b0;
      txd_r      <= 1'b1;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      baud_cnt_r <= baud_cnt_s;
      div_r      <= div_s;
      bit_cnt_r  <= bit_cnt_s;
      stop_cnt_r <= stop_cnt_s;
      shift_r    <= shift_s;
      par_bit_r  <= par_bit_s;
      par_en_r   <= par_en_s;
      two_stop_r <= two_stop_s;
      txd_r      <= txd_s;
      busy_r     <= busy_s;
      done_r     <= done_s;
    end
  end

  assign txd        = txd_r;
  assign busy       = busy_r;
  assign frame_done = done_r;

endmodule

// File: tb/tb_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_uart_tx -- scoreboard bench for uart_tx.
// Stimulus pushes bytes into a small FIFO model and, at the same time, the
// hand-computed expected frame (data, parity bit, length) into exp_q. A
// negedge monitor captures txd from the cycle after each rinc up to
// frame_done and compares the captured frame against the queue head.
// ---------------------------------------------------------------------------
module tb_uart_tx;

  logic        rclk;
  logic        rrst_n;
  logic        tx_en;
  logic [15:0] baud_div;
  logic        parity_en;
  logic        parity_odd;
  logic        two_stop;
  logic        rempty;
  logic [7:0]  rdata;
  logic        rinc;
  logic        txd;
  logic        busy;
  logic        frame_done;

  uart_tx #(.DSIZE(8), .DIV_WIDTH(16)) dut (
    .rclk       (rclk),
    .rrst_n     (rrst_n),
    .tx_en      (tx_en),
    .baud_div   (baud_div),
    .parity_en  (parity_en),
    .parity_odd (parity_odd),
    .two_stop   (two_stop),
    .rempty     (rempty),
    .rdata      (rdata),
    .rinc       (rinc),
    .txd        (txd),
    .busy       (busy),
    .frame_done (frame_done)
  );

  typedef struct {
    logic [7:0] data;
    int         div;
    bit         pe;
    bit         pbit;
    int         len;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] fq[$];

  int checks   = 0;
  int failures = 0;
  int rinc_cnt = 0;
  int b2b_cnt  = 0;
  bit pop_req  = 0;
  bit in_frame = 0;
  int ns       = 0;
  int busy_err = 0;
  bit samp [0:511];

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge rclk);
      #2;
    end
  endtask

  task automatic send(input logic [7:0] d, input bit pb, input int len);
    exp_t e;
    e.data = d; e.div = int'(baud_div); e.pe = parity_en; e.pbit = pb; e.len = len;
    exp_q.push_back(e);
    fq.push_back(d);
    rempty = 1'b0;
    rdata  = fq[0];
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || in_frame) && n < budget) begin
      tick(1);
      n++;
    end
    chk("drain_done", {31'd0, (exp_q.size() == 0 && !in_frame)}, 32'd1);
  endtask

  task automatic wait_rinc(input int target, input int budget);
    int n = 0;
    while (rinc_cnt < target && n < budget) begin
      tick(1);
      n++;
    end
    chk("rinc_seen", rinc_cnt, target);
  endtask

  // FIFO model: apply the pop seen in the previous cycle just after the edge.
  always @(posedge rclk) begin
    logic [7:0] tmp;
    #1;
    if (pop_req) begin
      if (fq.size() > 0) tmp = fq.pop_front();
      pop_req = 0;
    end
    rempty = (fq.size() == 0);
    rdata  = (fq.size() > 0) ? fq[0] : 8'h00;
  end

  // Monitor / scoreboard.
  always @(negedge rclk) begin
    exp_t e;
    int   bad;
    int   k;
    bit   expb;
    if (!rrst_n) begin
      in_frame = 0;
      pop_req  = 0;
    end else begin
      chk("rinc_gate", {31'd0, rinc & rempty}, 32'd0);
      if (in_frame) begin
        if (ns < 512) samp[ns] = txd;
        ns++;
        if (!busy) busy_err++;
        if (frame_done) begin
          in_frame = 0;
          if (exp_q.size() == 0) begin
            chk("frame_unexpected", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            chk("frame_len", ns, e.len);
            bad = 0;
            for (int i = 0; i < ns && i < 512; i++) begin
              k = i / (e.div + 1);
              if (k == 0)                 expb = 1'b0;
              else if (k <= 8)            expb = e.data[k-1];
              else if (e.pe && k == 9)    expb = e.pbit;
              else                        expb = 1'b1;
              if (samp[i] != expb) bad++;
            end
            chk("frame_bits", bad, 0);
            if (e.pe) chk("parity_bit", {31'd0, samp[9*(e.div+1)]}, {31'd0, e.pbit});
            chk("busy_in_frame", busy_err, 0);
          end
        end
      end else begin
        chk("idle_done_busy_txd", {29'd0, frame_done, busy, txd}, 32'd1);
      end
      if (rinc) begin
        rinc_cnt++;
        if (frame_done) b2b_cnt++;
        pop_req  = 1;
        in_frame = 1;
        ns       = 0;
        busy_err = 0;
      end
    end
  end

  initial begin
    int base;
    rrst_n = 1'b0; tx_en = 1'b0; baud_div = 16'd3;
    parity_en = 1'b0; parity_odd = 1'b0; two_stop = 1'b0;
    rempty = 1'b1; rdata = 8'h00;
    tick(3);
    chk("rst_txd",  {31'd0, txd},        32'd1);
    chk("rst_busy", {31'd0, busy},       32'd0);
    chk("rst_done", {31'd0, frame_done}, 32'd0);
    chk("rst_rinc", {31'd0, rinc},       32'd0);
    rrst_n = 1'b1;
    tick(2);

    // 8N1, baud_div=3, 0x55: 10 bits x 4 cycles
    tx_en = 1'b1;
    send(8'h55, 1'b0, 40);
    wait_drain(200);

    // Parity and stop-bit variants
    baud_div = 16'd1; parity_en = 1'b1; parity_odd = 1'b0;
    send(8'h07, 1'b1, 22);
    wait_drain(200);
    parity_odd = 1'b1;
    send(8'h07, 1'b0, 22);
    wait_drain(200);
    baud_div = 16'd0; parity_odd = 1'b0; two_stop = 1'b1;
    send(8'h07, 1'b1, 12);
    wait_drain(200);
    baud_div = 16'd2; parity_en = 1'b0;
    send(8'hFF, 1'b0, 33);
    wait_drain(200);

    // Back-to-back frames, second pop in the first frame's done cycle
    tx_en = 1'b0; baud_div = 16'd1; two_stop = 1'b0;
    send(8'hA5, 1'b0, 20);
    send(8'h3C, 1'b0, 20);
    base = b2b_cnt;
    tx_en = 1'b1;
    wait_drain(200);
    chk("b2b_pop_at_done", b2b_cnt, base + 1);

    // Empty FIFO with tx_en held: no pops, line idle
    base = rinc_cnt;
    tick(100);
    chk("empty_no_rinc", rinc_cnt, base);

    // Reset during data bit 3: frame abandoned, byte lost
    baud_div = 16'd3;
    base = rinc_cnt;
    send(8'h81, 1'b0, 40);
    wait_rinc(base + 1, 20);
    tick(17);
    rrst_n = 1'b0;
    #1;
    chk("midrst_txd",  {31'd0, txd},  32'd1);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_rinc", {31'd0, rinc}, 32'd0);
    if (exp_q.size() > 0) exp_q.delete(0);
    tick(2);
    rrst_n = 1'b1;
    tick(10);
    chk("postrst_no_rinc", rinc_cnt, base + 1);
    chk("postrst_idle", {31'd0, in_frame}, 32'd0);

    // tx_en dropped mid-frame with two bytes queued
    baud_div = 16'd0;
    base = rinc_cnt;
    send(8'h12, 1'b0, 10);
    send(8'h34, 1'b0, 10);
    wait_rinc(base + 1, 20);
    tick(3);
    tx_en = 1'b0;
    tick(25);
    chk("txen_off_one_pop", rinc_cnt, base + 1);
    chk("txen_off_pending", exp_q.size(), 1);
    tx_en = 1'b1;
    wait_drain(100);
    chk("txen_on_second_pop", rinc_cnt, base + 2);

    tick(3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
